// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Brief    : HI/LO multiply/divide sequencer for an iterative external divider.
//            Define MULDIV_MULT_MC_EN for a two-cycle registered multiply.
// Revision : 1.0
// ============================================================================
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_annul,
  output logic        stall,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        busy
);

  localparam logic [1:0] c_OP_MULT = 2'b00;
  localparam logic [1:0] c_OP_DIV  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_WAIT = 2'd1,
    S_MUL_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_signed;
  logic [63:0] r_result;

  logic        w_latch;
  logic        w_sign_next;
  logic        w_res_load;
  logic [63:0] w_res_next;
  logic        w_start_req;
  logic [31:0] w_mul_x;
  logic [31:0] w_mul_y;
  logic        w_mul_signed;
  logic [63:0] w_product;

  assign w_start_req = op_valid & op[1] & (b != 32'd0);

`ifdef MULDIV_MULT_MC_EN
  assign w_mul_x      = r_a;
  assign w_mul_y      = r_b;
  assign w_mul_signed = r_signed;
`else
  assign w_mul_x      = a;
  assign w_mul_y      = b;
  assign w_mul_signed = (op == c_OP_MULT);
`endif

  // Sign-extending both operands to 64 bits lets one unsigned multiplier serve MULT and MULTU.
  assign w_product = {{32{w_mul_signed & w_mul_x[31]}}, w_mul_x}
                   * {{32{w_mul_signed & w_mul_y[31]}}, w_mul_y};

  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_sign_next = r_signed;
    w_res_load  = 1'b0;
    w_res_next  = r_result;
    div_start   = 1'b0;
    div_annul   = 1'b0;
    stall       = 1'b0;
    hilo_we     = 1'b0;
    hilo_wdata  = '0;

    case (r_state)
      S_IDLE: begin
        if (op_valid && !flush) begin
          if (op[1]) begin
            stall = 1'b1;
            if (b != 32'd0) begin
              w_latch     = 1'b1;
              w_sign_next = (op == c_OP_DIV);
              w_next      = S_DIV_WAIT;
            end else begin
              w_res_load = 1'b1;
              w_res_next = {a, 32'hFFFF_FFFF};
              w_next     = S_DONE;
            end
          end else begin
`ifdef MULDIV_MULT_MC_EN
            stall       = 1'b1;
            w_latch     = 1'b1;
            w_sign_next = (op == c_OP_MULT);
            w_next      = S_MUL_WAIT;
`else
            hilo_we    = 1'b1;
            hilo_wdata = w_product;
`endif
          end
        end
      end
      S_DIV_WAIT: begin
        div_start = 1'b1;
        stall     = 1'b1;
        if (div_ready) begin
          w_res_load = 1'b1;
          w_res_next = div_result;
          w_next     = S_DONE;
        end
      end
      S_MUL_WAIT: begin
        stall      = 1'b1;
        w_res_load = 1'b1;
        w_res_next = w_product;
        w_next     = S_DONE;
      end
      S_DONE: begin
        hilo_we    = 1'b1;
        hilo_wdata = r_result;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // Flush overrides everything, including a divider result arriving this cycle.
    if (flush) begin
      stall      = 1'b0;
      hilo_we    = 1'b0;
      hilo_wdata = '0;
      w_latch    = 1'b0;
      w_res_load = 1'b0;
      w_next     = S_IDLE;
      div_annul  = (r_state == S_DIV_WAIT) | ((r_state == S_IDLE) & w_start_req);
    end

    // The divider is reset alongside us, so no abort and no architectural write.
    if (rst) begin
      div_annul  = 1'b0;
      hilo_we    = 1'b0;
      hilo_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_a      <= a;
        r_b      <= b;
        r_signed <= w_sign_next;
      end
      if (w_res_load) begin
        r_result <= w_res_next;
      end
    end
  end

  assign div_a      = r_a;
  assign div_b      = r_b;
  assign div_signed = r_signed;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ctrl
// Brief    : Scoreboard bench for muldiv_ctrl with a behavioural divider model.
// Revision : 1.0
// ============================================================================
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        div_ready;
  logic [63:0] div_result = '0;
  logic        div_start, div_signed, div_annul, stall, hilo_we, busy;
  logic [31:0] div_a, div_b;
  logic [63:0] hilo_wdata;

  logic        rdy_q = 1'b0;
  logic        spur = 1'b0;
  int          dv_lat = 5;
  int          dv_cnt = 0;
  bit          dv_run = 1'b0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  assign div_ready = rdy_q | spur;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .flush(flush), .div_ready(div_ready), .div_result(div_result),
    .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .div_annul(div_annul), .stall(stall), .hilo_we(hilo_we),
    .hilo_wdata(hilo_wdata), .busy(busy)
  );

  // {remainder, quotient}, truncating toward zero; divide-by-zero gives {x, all ones}
  function automatic logic [63:0] div_fn(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (sgn) begin
      sx = x;
      sy = y;
      return {32'(sx % sy), 32'(sx / sy)};
    end
    return {x % y, x / y};
  endfunction

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int ix, iy;
    longint sx, sy;
    longint unsigned ux, uy;
    case (o)
      2'b00: begin ix = x; iy = y; sx = ix; sy = iy; return sx * sy; end
      2'b01: begin ux = {32'd0, x}; uy = {32'd0, y}; return ux * uy; end
      2'b10: return div_fn(1'b1, x, y);
      default: return div_fn(1'b0, x, y);
    endcase
  endfunction

  // Divider: result becomes visible in the dv_lat-th cycle that start is held.
  always @(posedge clk) begin
    rdy_q <= 1'b0;
    if (rst || div_annul) begin
      dv_run <= 1'b0;
    end else if (div_start && !dv_run && !rdy_q) begin
      dv_run <= 1'b1;
      dv_cnt <= 1;
    end else if (dv_run) begin
      dv_cnt <= dv_cnt + 1;
      if (dv_cnt + 1 == dv_lat - 1) begin
        rdy_q      <= 1'b1;
        div_result <= div_fn(div_signed, div_a, div_b);
        dv_run     <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (hilo_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL hilo_write: got unexpected write %h, required no write", hilo_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (hilo_wdata !== mon_e) begin
            errors++;
            $display("FAIL hilo_wdata: got %h, required %h", hilo_wdata, mon_e);
          end
        end
      end
      checks++;
      if ((!hilo_we && hilo_wdata != 64'd0) || (div_annul && !flush)) begin
        errors++;
        $display("FAIL quiet_outputs: we=%b wdata=%h annul=%b flush=%b, required wdata=0 when idle and annul only with flush",
                 hilo_we, hilo_wdata, div_annul, flush);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    op_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit scramble);
    int stalls = 0;
    int cyc = 0;
    int exp_st;
    bit div_path;
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; a = x; b = y; flush = 1'b0;
    exp_q.push_back(ref_model(o, x, y));
    div_path = o[1] && (y != 32'd0);
    if (o[1]) exp_st = (y == 32'd0) ? 1 : 1 + dv_lat;
    else begin
`ifdef MULDIV_MULT_MC_EN
      exp_st = 2;
`else
      exp_st = 0;
`endif
    end
    @(negedge clk);
    chk("start_in_idle", {63'd0, div_start}, 64'd0);
    while (stall && cyc < 200) begin
      stalls++;
      if (cyc > 0 && div_path) begin
        chk("div_start", {63'd0, div_start}, 64'd1);
        chk("div_a", {32'd0, div_a}, {32'd0, x});
        chk("div_b", {32'd0, div_b}, {32'd0, y});
        chk("div_signed", {63'd0, div_signed}, {63'd0, (o == 2'b10)});
      end
      cyc++;
      @(posedge clk); #1;
      if (scramble) begin a = $urandom; b = $urandom; end
      @(negedge clk);
    end
    if (cyc >= 200) begin
      checks++; errors++;
      $display("FAIL op_timeout: stall still high after %0d cycles, required release", cyc);
    end
    chk("stall_cycles", 64'(stalls), 64'(exp_st));
  endtask

  task automatic div_flush(input int at_cyc, input int lat);
    dv_lat = lat;
    @(posedge clk); #1;
    op_valid = 1'b1; op = 2'b11; a = $urandom; b = $urandom | 32'd1; flush = 1'b0;
    for (int i = 0; i < at_cyc; i++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_annul", {63'd0, div_annul}, 64'd1);
    chk("flush_stall", {63'd0, stall}, 64'd0);
    chk("flush_we", {63'd0, hilo_we}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_start", {63'd0, div_start}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, {63'd0, stall}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_we"}, {63'd0, hilo_we}, 64'd0);
    chk({tag, "_wdata"}, hilo_wdata, 64'd0);
    chk({tag, "_start"}, {63'd0, div_start}, 64'd0);
    chk({tag, "_signed"}, {63'd0, div_signed}, 64'd0);
    chk({tag, "_div_a"}, {32'd0, div_a}, 64'd0);
    chk({tag, "_div_b"}, {32'd0, div_b}, 64'd0);
    chk({tag, "_annul"}, {63'd0, div_annul}, 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    mon_en = 1'b1;

    dv_lat = 33; run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    dv_lat = 7;  run_op(2'b11, 32'd10, 32'd3, 1'b1);
    run_op(2'b11, 32'd5, 32'd0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd4, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(2'b10, 32'h8000_0000, 32'd0, 1'b0);

    div_flush(5, 33);
    div_flush(6, 6);

    // flush on the cycle a division would start
    @(posedge clk); #1;
    op_valid = 1'b1; op = 2'b10; a = $urandom; b = 32'd9; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_annul", {63'd0, div_annul}, 64'd1);
    chk("idle_flush_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", {63'd0, busy}, 64'd0);

    // reset in the middle of a division
    dv_lat = 33;
    @(posedge clk); #1;
    op_valid = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_div_annul", {63'd0, div_annul}, 64'd0);
    chk("rst_div_we", {63'd0, hilo_we}, 64'd0);
    chk("rst_div_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check_all_zero("post_rst");

    // stray divider ready while idle
    @(posedge clk); #1;
    spur = 1'b1;
    @(negedge clk);
    chk("spur_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (ro == 2'b10 && rx == 32'h8000_0000 && ry == 32'hFFFF_FFFF) rx = 32'd0;
      dv_lat = $urandom_range(3, 12);
      run_op(ro, rx, ry, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle();
    end

    idle();
    idle();
    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
